mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles o_bus_req may stay high without i_bus_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_read_en  input  1  core load request, held high until o_read_vd.
REQ-005 i_write_en  input  1  core store request, one cycle per store unless o_exstall holds it.
REQ-006 i_addr  input  32  core byte address.
REQ-007 i_wdata  input  32  core store data.
REQ-008 o_rdata  output  32  load data, valid when o_read_vd=1.
REQ-009 o_read_vd  output  1  one-cycle load-complete pulse.
REQ-010 o_exstall  output  1  core stall request (combinational).
REQ-011 o_bus_req  output  1  bus request, registered.
REQ-012 o_bus_we  output  1  1=write, 0=read; valid while o_bus_req=1.
REQ-013 o_bus_addr  output  32  bus address; valid while o_bus_req=1.
REQ-014 o_bus_wdata  output  32  bus write data; valid while o_bus_req=1.
REQ-015 i_bus_ack  input  1  bus completion, sampled only while o_bus_req=1.
REQ-016 i_bus_rdata  input  32  bus read data, valid with i_bus_ack on reads.
REQ-017 o_bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 One-entry write buffer (wb_valid, wb_addr, wb_data) SHALL post stores without stalling the core.
REQ-019 Store accept: i_write_en=1 and wb_valid=0 -> capture i_addr/i_wdata, wb_valid<=1 next edge; o_exstall=0.
REQ-020 o_exstall SHALL equal i_write_en & wb_valid; a stalled store is captured the first cycle wb_valid=0.
REQ-021 FSM states: IDLE, WR_BUS, RD_BUS, RD_DONE.
REQ-022 IDLE: wb_valid=1 -> WR_BUS with o_bus_req=1, o_bus_we=1, buffer addr/data; else i_read_en=1 -> RD_BUS with o_bus_req=1, o_bus_we=0, o_bus_addr=i_addr.
REQ-023 Write drains before any read (store->load ordering); a pending load waits in IDLE.
REQ-024 While o_bus_req=1, o_bus_we/addr/wdata SHALL remain stable until ack or abort.
REQ-025 WR_BUS + i_bus_ack -> o_bus_req<=0, wb_valid<=0, state IDLE; stall released the cycle after ack.
REQ-026 RD_BUS + i_bus_ack -> o_rdata<=i_bus_rdata, state RD_DONE; o_read_vd=1 only in RD_DONE; RD_DONE -> IDLE unconditionally.
REQ-027 Min load latency: i_read_en first sampled cycle N -> o_bus_req cycle N+1 -> zero-wait ack cycle N+1 -> o_read_vd cycle N+2.
REQ-028 8-bit counter clears on entering WR_BUS/RD_BUS, increments each cycle req=1 and ack=0; at count==TIMEOUT abort.
REQ-029 Abort in RD_BUS: o_rdata<=0, RD_DONE, o_read_vd and o_bus_err pulse same cycle.
REQ-030 Abort in WR_BUS: write dropped, wb_valid<=0, IDLE, o_bus_err pulse one cycle.
REQ-031 Ack and timeout in same cycle: ack wins, no error.
REQ-032 i_read_en and i_write_en both 1: store path taken, load served after drain.
REQ-033 Store accept in the cycle wb clears (ack cycle) SHALL NOT occur; accept requires registered wb_valid=0.
REQ-034 i_bus_ack while o_bus_req=0 SHALL be ignored.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, wb_valid=0, counter=0, o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_rdata=0, o_read_vd=0, o_bus_err=0.
REQ-036 Reset mid-transaction SHALL abandon it with no o_read_vd or o_bus_err; o_exstall then follows REQ-020 with wb_valid=0.

Verification
REQ-037 Zero-wait load: i_read_en=1, i_addr=0x100, ack same cycle as req, i_bus_rdata=0xCAFEBABE -> o_read_vd=1 two cycles later, o_rdata=0xCAFEBABE.
REQ-038 Posted store: write_en 1 cycle, addr=0x200, data=0x11223344, ack after 3 cycles -> no o_exstall; req held 4 cycles stable; wb clears.
REQ-039 Back-to-back stores, ack delayed 5 cycles -> second store sees o_exstall=1 until cycle after first ack, then captured, issued with its own data.
REQ-040 Store then load to 0x300 -> bus write completes before bus read request; o_read_vd only after read ack.
REQ-041 Timeout: TIMEOUT=4, load, never ack -> req high 4 cycles, then o_read_vd=1, o_rdata=0, o_bus_err=1 single cycle.
REQ-042 Async reset asserted mid RD_BUS between edges -> o_bus_req=0 immediately, no o_read_vd after release.

Source files
------------

// File: rtl/mem_bridge_if.sv
`default_nettype none
// ============================================================================
// mem_bridge_if : core-side and bus-side signal bundle for mem_bridge
// Revision 1.0 : initial release
// ============================================================================
interface mem_bridge_if;
   logic        i_read_en;
   logic        i_write_en;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_read_vd;
   logic        o_exstall;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;
   logic        o_bus_err;

   // bridge view
   modport master (
      input  i_read_en, i_write_en, i_addr, i_wdata, i_bus_ack, i_bus_rdata,
      output o_rdata, o_read_vd, o_exstall, o_bus_req, o_bus_we, o_bus_addr,
             o_bus_wdata, o_bus_err
   );

   // core + bus-slave view
   modport slave (
      output i_read_en, i_write_en, i_addr, i_wdata, i_bus_ack, i_bus_rdata,
      input  o_rdata, o_read_vd, o_exstall, o_bus_req, o_bus_we, o_bus_addr,
             o_bus_wdata, o_bus_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// mem_bridge : core load/store to single-request bus bridge with a one-entry
//              posted write buffer and request timeout.
// Revision 1.0 : initial release
// ============================================================================
module mem_bridge #(
   parameter int TIMEOUT = 16
) (
   input  wire logic    clk,
   input  wire logic    rst,
   mem_bridge_if.master mb
);
   localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR_BUS  = 2'd1,
      S_RD_BUS  = 2'd2,
      S_RD_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_wb_valid;
   logic [31:0] r_wb_addr;
   logic [31:0] r_wb_data;
   logic [7:0]  r_cnt;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_rdata;
   logic        r_bus_err;

   logic        w_accept;
   logic        w_timeout;
   logic        w_start_wr;
   logic        w_start_rd;
   logic        w_done;
   logic        w_abort;
   logic        w_wr_end;
   logic        w_rd_end;

   assign w_accept     = mb.i_write_en & ~r_wb_valid;
   assign w_timeout    = (r_cnt == C_TMO_LAST);

   assign mb.o_exstall   = mb.i_write_en & r_wb_valid;
   assign mb.o_read_vd   = (r_state == S_RD_DONE);
   assign mb.o_rdata     = r_rdata;
   assign mb.o_bus_req   = r_bus_req;
   assign mb.o_bus_we    = r_bus_we;
   assign mb.o_bus_addr  = r_bus_addr;
   assign mb.o_bus_wdata = r_bus_wdata;
   assign mb.o_bus_err   = r_bus_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start_wr = 1'b0;
      w_start_rd = 1'b0;
      w_done     = 1'b0;
      w_abort    = 1'b0;
      w_wr_end   = 1'b0;
      w_rd_end   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A load waits while a store is buffered or being presented this cycle
            if (r_wb_valid) begin
               w_next     = S_WR_BUS;
               w_start_wr = 1'b1;
            end else if (mb.i_read_en && !mb.i_write_en) begin
               w_next     = S_RD_BUS;
               w_start_rd = 1'b1;
            end
         end
         S_WR_BUS: begin
            w_done   = mb.i_bus_ack;
            w_abort  = ~mb.i_bus_ack & w_timeout;
            w_wr_end = w_done | w_abort;
            if (w_wr_end) w_next = S_IDLE;
         end
         S_RD_BUS: begin
            w_done   = mb.i_bus_ack;
            w_abort  = ~mb.i_bus_ack & w_timeout;
            w_rd_end = w_done | w_abort;
            if (w_rd_end) w_next = S_RD_DONE;
         end
         S_RD_DONE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_cnt       <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_bus_err <= w_abort;

         if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= mb.i_addr;
            r_wb_data  <= mb.i_wdata;
         end else if (w_wr_end) begin
            r_wb_valid <= 1'b0;
         end

         if (w_start_wr || w_start_rd) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_start_wr;
            r_bus_addr  <= w_start_wr ? r_wb_addr : mb.i_addr;
            r_bus_wdata <= r_wb_data;
            r_cnt       <= '0;
         end else if (w_done || w_abort) begin
            r_bus_req <= 1'b0;
         end else if (r_bus_req) begin
            r_cnt <= r_cnt + 8'd1;
         end

         if (w_rd_end) r_rdata <= w_done ? mb.i_bus_rdata : 32'd0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// tb_mem_bridge : directed + randomized checks of mem_bridge against a
//                 transaction-level memory model and bus-slave responder.
// Revision 1.0 : initial release
// ============================================================================
module tb_mem_bridge;
   localparam int C_TMO = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bridge_if mb();

   mem_bridge #(.TIMEOUT(C_TMO)) u_dut (
      .clk (clk),
      .rst (rst),
      .mb  (mb)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // core-visible memory (model) and bus-slave memory (what the bus really saw)
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];
   logic [63:0] exp_wr_q [$];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction
   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
   endfunction

   // bus slave: ack once the request has been held ack_delay cycles (-1 = never)
   int ack_delay = 0;
   int rsp_cnt   = 0;
   always @(posedge clk) begin
      #1;
      if (mb.o_bus_req) begin
         mb.i_bus_ack   = (ack_delay >= 0) && (rsp_cnt >= ack_delay);
         mb.i_bus_rdata = (mb.i_bus_ack && !mb.o_bus_we) ? slv_rd(mb.o_bus_addr) : $urandom;
         rsp_cnt++;
      end else begin
         mb.i_bus_ack   = ($urandom_range(0, 3) == 0);
         mb.i_bus_rdata = $urandom;
         rsp_cnt        = 0;
      end
   end

   // bus monitor: stability, write order/content, store->load ordering
   logic        h_hold = 1'b0;
   logic        h_we   = 1'b0;
   logic [31:0] h_addr = '0;
   logic [31:0] h_wdata = '0;
   int cur_len = 0, last_len = 0, err_cnt = 0, vd_cnt = 0;
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst) begin
         h_hold  = 1'b0;
         cur_len = 0;
      end else begin
         if (mb.o_bus_err) begin
            err_cnt++;
            if (h_we && exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
         end
         if (mb.o_read_vd) vd_cnt++;
         if (mb.o_bus_req) begin
            if (h_hold) begin
               check("bus_we_stable", 32'(mb.o_bus_we), 32'(h_we));
               check("bus_addr_stable", mb.o_bus_addr, h_addr);
               if (h_we) check("bus_wdata_stable", mb.o_bus_wdata, h_wdata);
            end else if (!mb.o_bus_we) begin
               check("rd_after_wr_drain", 32'(exp_wr_q.size()), 32'd0);
            end
            h_we    = mb.o_bus_we;
            h_addr  = mb.o_bus_addr;
            h_wdata = mb.o_bus_wdata;
            cur_len++;
            if (mb.i_bus_ack) begin
               h_hold = 1'b0;
               if (mb.o_bus_we) begin
                  if (exp_wr_q.size() == 0) begin
                     check("wr_unexpected", 32'd1, 32'd0);
                  end else begin
                     e = exp_wr_q.pop_front();
                     check("wr_addr", mb.o_bus_addr, e[63:32]);
                     check("wr_data", mb.o_bus_wdata, e[31:0]);
                  end
                  slv_mem[mb.o_bus_addr] = mb.o_bus_wdata;
               end
            end else begin
               h_hold = 1'b1;
            end
         end else begin
            h_hold = 1'b0;
            if (cur_len != 0) begin
               last_len = cur_len;
               cur_len  = 0;
            end
         end
      end
   end

   // one core operation; st_n/ld_n = cycles from start to store accept / load valid
   task automatic core_op(input bit st, input bit ld, input logic [31:0] a,
                          input logic [31:0] d, output int st_n, output int ld_n);
      bit st_p, ld_p;
      int n;
      st_p = st; ld_p = ld; n = 0; st_n = -1; ld_n = -1;
      mb.i_addr = a; mb.i_wdata = d; mb.i_write_en = st; mb.i_read_en = ld;
      while ((st_p || ld_p) && n < 100) begin
         @(negedge clk);
         if (st_p && !mb.o_exstall) begin
            exp_wr_q.push_back({a, d});
            ref_mem[a] = d;
            st_p = 1'b0;
            st_n = n;
         end
         if (ld_p && mb.o_read_vd) begin
            check("load_data", mb.o_rdata, ref_rd(a));
            check("load_err", 32'(mb.o_bus_err), 32'd0);
            ld_p = 1'b0;
            ld_n = n;
         end
         @(posedge clk); #1;
         mb.i_write_en = st_p;
         mb.i_read_en  = ld_p;
         n++;
      end
      check("core_op_done", 32'(st_p || ld_p), 32'd0);
   endtask

   task automatic wait_quiet();
      int q, n;
      q = 0; n = 0;
      while (q < 3 && n < 100) begin
         @(negedge clk);
         q = mb.o_bus_req ? 0 : q + 1;
         n++;
         @(posedge clk); #1;
      end
      check("quiet_wait", 32'(q < 3), 32'd0);
   endtask

   initial begin
      int sn, ln, n, e0, v0, kind;
      logic [31:0] a, d;
      mb.i_read_en = 1'b0; mb.i_write_en = 1'b0; mb.i_addr = '0; mb.i_wdata = '0;

      // reset state, with a store presented during reset
      repeat (2) @(posedge clk); #1;
      mb.i_write_en = 1'b1;
      @(negedge clk);
      check("rst_bus_req", 32'(mb.o_bus_req), 32'd0);
      check("rst_bus_we", 32'(mb.o_bus_we), 32'd0);
      check("rst_bus_addr", mb.o_bus_addr, 32'd0);
      check("rst_bus_wdata", mb.o_bus_wdata, 32'd0);
      check("rst_rdata", mb.o_rdata, 32'd0);
      check("rst_read_vd", 32'(mb.o_read_vd), 32'd0);
      check("rst_bus_err", 32'(mb.o_bus_err), 32'd0);
      check("rst_exstall", 32'(mb.o_exstall), 32'd0);
      @(posedge clk); #1;
      mb.i_write_en = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // zero-wait load
      ack_delay = 0;
      slv_mem[32'h100] = 32'hCAFEBABE;
      ref_mem[32'h100] = 32'hCAFEBABE;
      mb.i_addr = 32'h100; mb.i_read_en = 1'b1;
      @(negedge clk);
      check("zw_req_n0", 32'(mb.o_bus_req), 32'd0);
      @(posedge clk); #1; @(negedge clk);
      check("zw_req_n1", 32'(mb.o_bus_req), 32'd1);
      check("zw_we_n1", 32'(mb.o_bus_we), 32'd0);
      check("zw_addr_n1", mb.o_bus_addr, 32'h100);
      @(posedge clk); #1; @(negedge clk);
      check("zw_vd_n2", 32'(mb.o_read_vd), 32'd1);
      check("zw_rdata_n2", mb.o_rdata, 32'hCAFEBABE);
      @(posedge clk); #1;
      mb.i_read_en = 1'b0;
      @(negedge clk);
      check("zw_vd_pulse", 32'(mb.o_read_vd), 32'd0);
      @(posedge clk); #1;

      // posted store, ack after 3 cycles
      ack_delay = 3;
      core_op(1'b1, 1'b0, 32'h200, 32'h11223344, sn, ln);
      check("ps_no_stall", 32'(sn), 32'd0);
      wait_quiet();
      check("ps_req_len", 32'(last_len), 32'd4);
      check("ps_mem", slv_rd(32'h200), 32'h11223344);

      // back-to-back stores; ack at the last pre-timeout cycle must win
      ack_delay = 5;
      e0 = err_cnt;
      core_op(1'b1, 1'b0, 32'h204, 32'hA0A0A0A0, sn, ln);
      check("b2b_first_no_stall", 32'(sn), 32'd0);
      core_op(1'b1, 1'b0, 32'h208, 32'hB0B0B0B0, sn, ln);
      check("b2b_stall_cycles", 32'(sn), 32'(5 + 2));
      wait_quiet();
      check("b2b_mem0", slv_rd(32'h204), 32'hA0A0A0A0);
      check("b2b_mem1", slv_rd(32'h208), 32'hB0B0B0B0);
      check("b2b_req_len", 32'(last_len), 32'd6);
      check("b2b_no_err", 32'(err_cnt - e0), 32'd0);

      // store then load same address: write drains first
      ack_delay = 2;
      core_op(1'b1, 1'b0, 32'h300, 32'h55AA33CC, sn, ln);
      core_op(1'b0, 1'b1, 32'h300, 32'h0, sn, ln);
      check("st_ld_latency", 32'(ln), 32'd8);

      // load timeout
      ack_delay = -1;
      e0 = err_cnt;
      mb.i_addr = 32'h40; mb.i_read_en = 1'b1; n = 0;
      @(negedge clk);
      while (!mb.o_read_vd && n < 50) begin
         @(posedge clk); #1; @(negedge clk);
         n++;
      end
      check("to_cycles", 32'(n), 32'(C_TMO + 1));
      check("to_vd", 32'(mb.o_read_vd), 32'd1);
      check("to_rdata", mb.o_rdata, 32'd0);
      check("to_err", 32'(mb.o_bus_err), 32'd1);
      @(posedge clk); #1;
      mb.i_read_en = 1'b0;
      @(negedge clk);
      check("to_err_pulse", 32'(mb.o_bus_err), 32'd0);
      check("to_req_len", 32'(last_len), 32'(C_TMO));
      @(posedge clk); #1;

      // store timeout: write dropped
      e0 = err_cnt;
      core_op(1'b1, 1'b0, 32'h500, 32'hDEAD0001, sn, ln);
      ref_mem.delete(32'h500);
      wait_quiet();
      check("wto_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("wto_dropped", slv_rd(32'h500), init_val(32'h500));
      check("wto_q_empty", 32'(exp_wr_q.size()), 32'd0);
      check("wto_req_len", 32'(last_len), 32'(C_TMO));

      // asynchronous reset in the middle of a read
      v0 = vd_cnt; e0 = err_cnt;
      mb.i_addr = 32'h44; mb.i_read_en = 1'b1; n = 0;
      @(negedge clk);
      while (!mb.o_bus_req && n < 20) begin
         @(posedge clk); #1; @(negedge clk);
         n++;
      end
      check("ar_req_seen", 32'(mb.o_bus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_req_async", 32'(mb.o_bus_req), 32'd0);
      check("ar_addr_async", mb.o_bus_addr, 32'd0);
      mb.i_read_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      check("ar_no_vd", 32'(vd_cnt - v0), 32'd0);
      check("ar_no_err", 32'(err_cnt - e0), 32'd0);

      // randomized traffic
      e0 = err_cnt;
      for (int i = 0; i < 250; i++) begin
         kind      = $urandom_range(0, 3);
         a         = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         d         = $urandom;
         ack_delay = $urandom_range(0, C_TMO - 1);
         case (kind)
            0: core_op(1'b1, 1'b0, a, d, sn, ln);
            1: core_op(1'b0, 1'b1, a, d, sn, ln);
            2: core_op(1'b1, 1'b1, a, d, sn, ln);
            default: repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         endcase
      end
      wait_quiet();
      check("rnd_q_empty", 32'(exp_wr_q.size()), 32'd0);
      check("rnd_no_err", 32'(err_cnt - e0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
